// File: rtl/gpio_bus_arbiter.sv
// Two-master round-robin front end for the GPIO register-bus slave port.
// Registers the slave request, times out silent addresses and waits for s_ready to drop between accesses.

module gpio_bus_arbiter_resp (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic        sel,
  input  logic        timeout,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        ready,
  output logic        error
);

  // Read data is held until this master's next completion; a timeout returns zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      ready <= 1'b0;
      error <= 1'b0;
    end else begin
      ready <= done && sel;
      error <= done && sel && timeout;
      if (done && sel)
        data <= timeout ? '0 : rdata;
    end
  end

endmodule

module gpio_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_wr,
  input  logic        m0_enable,
  output logic [31:0] m0_data_o,
  output logic        m0_ready,
  output logic        m0_error,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_wr,
  input  logic        m1_enable,
  output logic [31:0] m1_data_o,
  output logic        m1_ready,
  output logic        m1_error,
  output logic [31:0] s_address,
  output logic [31:0] s_data_o,
  output logic [3:0]  s_wr,
  output logic        s_enable,
  input  logic [31:0] s_data_i,
  input  logic        s_ready
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic              grant;
  logic              last_grant;
  logic              gnt_next;
  logic [7:0]        counter;
  logic              done;
  logic              timeout;

  logic [1:0][31:0]  m_address;
  logic [1:0][31:0]  m_data_w;
  logic [1:0][31:0]  m_data_r;
  logic [1:0][3:0]   m_wr;
  logic [1:0]        m_enable;
  logic [1:0]        m_ready;
  logic [1:0]        m_error;

  assign m_address = {m1_address, m0_address};
  assign m_data_w  = {m1_data_i, m0_data_i};
  assign m_wr      = {m1_wr, m0_wr};
  assign m_enable  = {m1_enable, m0_enable};

  assign m0_data_o = m_data_r[0];
  assign m0_ready  = m_ready[0];
  assign m0_error  = m_error[0];
  assign m1_data_o = m_data_r[1];
  assign m1_ready  = m_ready[1];
  assign m1_error  = m_error[1];

  // A tie goes to whoever did not win last; a lone requester wins outright.
  assign gnt_next = (&m_enable) ? ~last_grant : m_enable[1];

  assign done    = (state == BUSY) && (s_ready || (counter == TO_LAST));
  assign timeout = !s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      counter    <= '0;
      s_address  <= '0;
      s_data_o   <= '0;
      s_wr       <= '0;
      s_enable   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_enable) begin
            grant      <= gnt_next;
            last_grant <= gnt_next;
            s_address  <= m_address[gnt_next];
            s_data_o   <= m_data_w[gnt_next];
            s_wr       <= m_wr[gnt_next];
            s_enable   <= 1'b1;
            counter    <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          counter <= counter + 8'd1;
          if (done) begin
            s_enable <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          // The slave must show ready low before it sees the next enable edge.
          if (!s_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    gpio_bus_arbiter_resp u_resp (
      .clk     (clk),
      .rst     (rst),
      .done    (done),
      .sel     (grant == 1'(i)),
      .timeout (timeout),
      .rdata   (s_data_i),
      .data    (m_data_r[i]),
      .ready   (m_ready[i]),
      .error   (m_error[i])
    );
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: register-file slave model, vector table, directed corner sequences
// and a randomized two-master run checked against a word-level memory model.

module tb_gpio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_address = '0, m0_data_i = '0, m1_address = '0, m1_data_i = '0;
  logic [3:0]  m0_wr = '0, m1_wr = '0;
  logic        m0_enable = 1'b0, m1_enable = 1'b0;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ready, m0_error, m1_ready, m1_error;
  logic [31:0] s_address, s_data_o, s_data_i;
  logic [3:0]  s_wr;
  logic        s_enable, s_ready;

  int checks = 0;
  int errors = 0;

  gpio_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_data_i(m0_data_i), .m0_wr(m0_wr), .m0_enable(m0_enable),
    .m0_data_o(m0_data_o), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_address(m1_address), .m1_data_i(m1_data_i), .m1_wr(m1_wr), .m1_enable(m1_enable),
    .m1_data_o(m1_data_o), .m1_ready(m1_ready), .m1_error(m1_error),
    .s_address(s_address), .s_data_o(s_data_o), .s_wr(s_wr), .s_enable(s_enable),
    .s_data_i(s_data_i), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  // Slave: 16 word registers, registered ready/data, write on the enable rising edge, 0x14 never acks.
  logic [31:0] smem [16];
  logic        s_en_q = 1'b0;
  int          wcount = 0;
  logic [35:0] log_q [$];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (w[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) smem[i] = 32'h1000_0000 + 32'h0101 * i;
    smem[1] = 32'h0000_00FF;
    s_ready  = 1'b0;
    s_data_i = '0;
  end

  always @(posedge clk) begin
    s_en_q   <= s_enable;
    s_ready  <= s_enable && (s_address != 32'h14);
    s_data_i <= smem[s_address[5:2]];
    if (s_enable && !s_en_q) begin
      log_q.push_back({s_wr, s_address});
      if (s_wr != 4'b0000 && s_address != 32'h14) begin
        smem[s_address[5:2]] = merge(smem[s_address[5:2]], s_data_o, s_wr);
        wcount = wcount + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one access from idle-aligned time (posedge+1); lat counts edges until the ready pulse is seen.
  task automatic txn(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                     output logic [31:0] rd, output logic e, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    if (m == 0) begin m0_address = a; m0_data_i = d; m0_wr = w; m0_enable = 1'b1; end
    else        begin m1_address = a; m1_data_i = d; m1_wr = w; m1_enable = 1'b1; end
    while (!got && lat < 300) begin
      @(posedge clk); #1;
      lat = lat + 1;
      got = (m == 0) ? m0_ready : m1_ready;
    end
    rd = (m == 0) ? m0_data_o : m1_data_o;
    e  = (m == 0) ? m0_error : m1_error;
    if (!got) begin
      chk("ready_timeout", 32'(lat), 32'd0);
      lat = -1;
    end
    if (m == 0) m0_enable = 1'b0; else m1_enable = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wr;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] rd, shadow [16];
  logic        e;
  int          lat, w0, t_first;

  initial begin
    tbl[0] = '{0, 32'h04, 32'h0,         4'b0000, 32'h0000_00FF, 1'b0, 3};
    tbl[1] = '{1, 32'h08, 32'h0,         4'b0000, 32'h1000_0202, 1'b0, 3};
    tbl[2] = '{1, 32'h14, 32'h0,         4'b0000, 32'h0,         1'b1, 17};
    tbl[3] = '{0, 32'h0C, 32'hDEADBEEF,  4'b1111, 32'h1000_0303, 1'b0, 3};
    tbl[4] = '{1, 32'h0C, 32'h0,         4'b0000, 32'hDEADBEEF,  1'b0, 3};
    tbl[5] = '{0, 32'h0C, 32'h0000_00AA, 4'b0001, 32'hDEADBEEF,  1'b0, 3};
    tbl[6] = '{1, 32'h0C, 32'h0,         4'b0000, 32'hDEADBEAA,  1'b0, 3};
    tbl[7] = '{0, 32'h10, 32'h1234_5678, 4'b1100, 32'h1000_0404, 1'b0, 3};
    tbl[8] = '{0, 32'h10, 32'h0,         4'b0000, 32'h1234_0404, 1'b0, 3};
    tbl[9] = '{0, 32'h14, 32'h0,         4'b0000, 32'h0,         1'b1, 17};

    // Reset state
    @(posedge clk); #1;
    do_reset();
    chk("rst_s_enable", 32'(s_enable), 32'd0);
    chk("rst_s_address", s_address, 32'd0);
    chk("rst_s_wr", 32'(s_wr), 32'd0);
    chk("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk("rst_m1_error", 32'(m1_error), 32'd0);
    chk("rst_m0_data", m0_data_o, 32'd0);

    // Latency trace of a single read: s_enable in cycles 1-2, ready only in cycle 3
    m0_address = 32'h04; m0_wr = 4'b0000; m0_enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("trace_s_enable_c%0d", k), 32'(s_enable), (k == 1 || k == 2) ? 32'd1 : 32'd0);
      chk($sformatf("trace_m0_ready_c%0d", k), 32'(m0_ready), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) m0_enable = 1'b0;
    end
    gap(2);

    // Vector table, each access started from idle
    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].m, tbl[i].addr, tbl[i].data, tbl[i].wr, rd, e, lat);
      chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_data);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      gap(3);
    end

    // Tie after reset goes to m0; m1 waits one full transaction
    do_reset();
    log_q.delete();
    fork
      begin
        logic [31:0] r0; logic e0; int l0;
        txn(0, 32'h00, 32'h0000_00A5, 4'b0001, r0, e0, l0);
        chk("tie_m0_lat", 32'(l0), 32'd3);
      end
      begin
        logic [31:0] r1; logic e1; int l1;
        txn(1, 32'h08, 32'h0, 4'b0000, r1, e1, l1);
        chk("tie_m1_lat", 32'(l1), 32'd8);
        chk("tie_m1_data", r1, 32'h1000_0202);
      end
    join
    chk("tie_first", {log_q[0]}, {4'b0001, 32'h00});
    chk("tie_second", {log_q[1]}, {4'b0000, 32'h08});
    gap(3);
    txn(0, 32'h00, 32'h0, 4'b0000, rd, e, lat);
    chk("tie_wr_result", rd, 32'h1000_00A5);
    gap(3);
    log_q.delete();
    fork
      begin logic [31:0] r0; logic e0; int l0; txn(0, 32'h20, 32'h0, 4'b0000, r0, e0, l0); end
      begin logic [31:0] r1; logic e1; int l1; txn(1, 32'h24, 32'h0, 4'b0000, r1, e1, l1); end
    join
    chk("tie2_first_m1", log_q[0][31:0], 32'h24);
    gap(3);

    // Back-to-back writes with enable held: one slave write each, 5-cycle spacing
    w0 = wcount;
    m0_address = 32'h18; m0_data_i = 32'h1111_1111; m0_wr = 4'b1111; m0_enable = 1'b1;
    lat = 0; t_first = -1;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat = lat + 1;
      if (m0_ready && t_first < 0) begin
        t_first = lat;
        chk("b2b_first_data", m0_data_o, 32'h1000_0606);
        m0_data_i = 32'h2222_2222;
      end else if (m0_ready) begin
        break;
      end
      if (t_first > 0 && lat > t_first && lat < t_first + 3)
        chk($sformatf("b2b_gap_s_enable_c%0d", lat), 32'(s_enable), 32'd0);
    end
    m0_enable = 1'b0;
    chk("b2b_spacing", 32'(lat - t_first), 32'd5);
    chk("b2b_second_data", m0_data_o, 32'h1111_1111);
    chk("b2b_write_count", 32'(wcount - w0), 32'd2);
    gap(3);
    txn(1, 32'h18, 32'h0, 4'b0000, rd, e, lat);
    chk("b2b_final", rd, 32'h2222_2222);
    gap(3);

    // Reset during the second BUSY cycle
    m0_address = 32'h04; m0_wr = 4'b0000; m0_enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m0_enable = 1'b0;
    chk("irq_s_enable", 32'(s_enable), 32'd0);
    chk("irq_m0_ready", 32'(m0_ready), 32'd0);
    chk("irq_m0_error", 32'(m0_error), 32'd0);
    chk("irq_m0_data", m0_data_o, 32'd0);
    @(posedge clk); #1;
    chk("irq_no_pulse", 32'(m0_ready), 32'd0);
    gap(2);
    txn(0, 32'h04, 32'h0, 4'b0000, rd, e, lat);
    chk("irq_after_lat", 32'(lat), 32'd3);
    chk("irq_after_data", rd, 32'h0000_00FF);

    // Continuous contention: strict alternation starting with m0
    do_reset();
    log_q.delete();
    fork
      for (int i = 0; i < 4; i++) begin
        logic [31:0] r0; logic e0; int l0;
        txn(0, 32'h20, 32'h0, 4'b0000, r0, e0, l0);
        chk("rr_m0_err", 32'(e0), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
        logic [31:0] r1; logic e1; int l1;
        txn(1, 32'h24, 32'h0, 4'b0000, r1, e1, l1);
        chk("rr_m1_err", 32'(e1), 32'd0);
      end
    join
    chk("rr_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < log_q.size(); i++)
      chk($sformatf("rr_order_%0d", i), log_q[i][31:0], (i % 2 == 0) ? 32'h20 : 32'h24);
    gap(3);

    // Randomized traffic: m0 owns words 0-7 (incl. the silent 0x14), m1 owns 8-15
    for (int i = 0; i < 16; i++) shadow[i] = smem[i];
    fork
      for (int n = 0; n < 25; n++) begin
        int r; logic [3:0] w; logic [31:0] d, xd, ad; logic xe, re; int l;
        r = $urandom_range(0, 7);
        w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        d = $urandom;
        ad = 32'(r * 4);
        xe = (ad == 32'h14);
        xd = xe ? 32'h0 : shadow[r];
        if (!xe && w != 4'b0000) shadow[r] = merge(shadow[r], d, w);
        txn(0, ad, d, w, ad, re, l);
        chk("rnd_m0_data", ad, xd);
        chk("rnd_m0_err", 32'(re), 32'(xe));
        gap($urandom_range(0, 3));
      end
      for (int n = 0; n < 25; n++) begin
        int r; logic [3:0] w; logic [31:0] d, xd, rdv; logic re; int l;
        r = $urandom_range(8, 15);
        w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        d = $urandom;
        xd = shadow[r];
        if (w != 4'b0000) shadow[r] = merge(shadow[r], d, w);
        txn(1, 32'(r * 4), d, w, rdv, re, l);
        chk("rnd_m1_data", rdv, xd);
        chk("rnd_m1_err", 32'(re), 32'd0);
        gap($urandom_range(0, 3));
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
